fifo_drain_ctrl: RTL
====================

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of FIFO read data and output stream data.
REQ-002 Parameter BURST_LEN, default 4, legal range 1..256: number of accepted beats per burst; m_last marks the final beat.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 en  input  1  drain enable; high = fetch words from FIFO.
REQ-006 fifo_empty  input  1  FIFO empty flag; updated at the same edge that commits a read.
REQ-007 fifo_data  input  DATA_WIDTH  FIFO read data; registered, valid the cycle after a read strobe.
REQ-008 fifo_rd_cs  output  1  FIFO read chip-select; always equal to fifo_rd_en.
REQ-009 fifo_rd_en  output  1  FIFO read strobe; one word per high cycle.
REQ-010 m_valid  output  1  output stream word valid.
REQ-011 m_data  output  DATA_WIDTH  output stream data.
REQ-012 m_last  output  1  final beat of a burst; qualified by m_valid.
REQ-013 m_ready  input  1  downstream accept; beat transfers when m_valid && m_ready.
REQ-014 busy  output  1  high whenever state != IDLE or any word is in flight or buffered.

Function
REQ-015 Read latency SHALL be one cycle: a word strobed at edge t SHALL be captured from fifo_data at edge t+1 into a 2-entry skid buffer.
REQ-016 Credit rule: fifo_rd_en SHALL assert only when en=1, fifo_empty=0, state=RUN, and (buffered + in_flight) < 2 after counting a beat transferring this cycle.
REQ-017 Back-to-back reads SHALL be allowed; sustained throughput SHALL be one word per cycle while m_ready=1.
REQ-018 Buffer SHALL never overflow; no FIFO word SHALL be dropped, duplicated or reordered.
REQ-019 m_valid SHALL be high while the buffer holds at least one word; m_data SHALL be the oldest word; m_valid/m_data SHALL stay stable until accepted.
REQ-020 States: IDLE, RUN, STOP. IDLE->RUN when en=1. RUN->STOP when en=0. STOP issues no reads; STOP->IDLE when in_flight=0 and buffer empty. STOP->RUN if en=1 again.
REQ-021 Beat counter (width ceil(log2(BURST_LEN))+1) SHALL increment per accepted beat, wrapping to 0 after BURST_LEN-1; m_last = m_valid && (count == BURST_LEN-1). BURST_LEN=1 -> m_last high on every valid beat.
REQ-022 Beat counter SHALL clear on the STOP->IDLE transition (partial bursts are not resumed).
REQ-023 fifo_empty=1 in RUN SHALL suppress reads without state change; m_valid drops once buffer drains.
REQ-024 m_ready=0 with buffer full SHALL suppress reads until a beat transfers.

Reset
REQ-025 rst SHALL immediately force: state IDLE, buffer empty, in_flight 0, beat count 0, fifo_rd_en/fifo_rd_cs 0, m_valid 0, m_data 0, m_last 0, busy 0.
REQ-026 Reset mid-operation SHALL discard buffered and in-flight words; fifo_data after release SHALL be ignored until a new strobe.

Configuration
REQ-027 Macro FIFO_DRAIN_STATS_EN defined: add output drained_cnt [15:0], counting accepted beats, wrap 0xFFFF->0, reset 0. Undefined: port and counter absent; all other behaviour identical.

Structure
REQ-028 Shared package fifo_pkg SHALL hold the state encoding (IDLE/RUN/STOP), default DATA_WIDTH and the stats counter width (16).
REQ-029 The 2-entry skid buffer SHALL be a sub-module, drain_skid_buf (push, pop, data, count, full, empty).

Verification
REQ-030 FIFO preloaded 0x11,0x22,0x33,0x44, en=1, m_ready=1 -> rd_en high 4 consecutive cycles, m_data 0x11..0x44 on consecutive cycles, m_last on 0x44 (BURST_LEN=4).
REQ-031 8 words, m_ready toggling 1/0 each cycle -> all 8 delivered in order, never more than 2 buffered, rd_en never high when credit exhausted.
REQ-032 2 words queued, en dropped after first strobe -> STOP, word 2 not read, word 1 delivered, then IDLE, busy=0, beat count 0.
REQ-033 FIFO empties mid-burst (3 of 4 beats), refilled 5 cycles later -> m_valid gap, 4th beat carries m_last.
REQ-034 rst pulsed with 2 buffered words and 1 in flight -> all outputs 0 same cycle; after release with FIFO empty, m_valid stays 0.
REQ-035 FIFO_DRAIN_STATS_EN defined, 10 beats accepted -> drained_cnt = 10; rst -> 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the FIFO drain controller slice.
//   drain_state_e      : controller state encoding (IDLE / RUN / STOP)
//   DEFAULT_DATA_WIDTH : default width of FIFO read data and stream data
//   STATS_CNT_W        : width of the optional drained-beat counter
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } drain_state_e;

    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int STATS_CNT_W        = 16;

endpackage

// File: rtl/fifo_drain_ctrl_if.sv
// fifo_drain_ctrl_if: output stream of the FIFO drain controller.
//   m_valid : word valid (master -> slave)
//   m_data  : oldest buffered word (master -> slave)
//   m_last  : final beat of a burst, qualified by m_valid (master -> slave)
//   m_ready : downstream accept (slave -> master)
// Handshake: a beat transfers on a rising edge where m_valid && m_ready.
// Once m_valid is high, m_valid/m_data/m_last hold steady until that
// transfer; m_ready may change freely and never depends on m_valid.
interface fifo_drain_ctrl_if
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) ();

    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_last;
    logic                  m_ready;

    modport master (
        output m_valid,
        output m_data,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_valid,
        input  m_data,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/fifo_drain_ctrl_skid_buf.sv
// drain_skid_buf: two-entry in-order buffer for words returning from the FIFO.
//   clk, rst : clock, asynchronous active-high reset
//   push_i   : write data_i this cycle
//   pop_i    : remove the oldest entry this cycle
//   data_i   : word to write
//   data_o   : oldest entry (0 when empty)
//   count_o  : entries held (0..2)
//   full_o   : count_o == 2
//   empty_o  : count_o == 0
// Push and pop may occur together. The caller guarantees no push while full
// without a pop, and no pop while empty.
module drain_skid_buf
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            count_o,
    output logic                  full_o,
    output logic                  empty_o
);

    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        case ({push_i, pop_i})
            2'b10: begin
                if (count_q == 2'd0) begin
                    head_d  = data_i;
                    count_d = 2'd1;
                end else if (count_q == 2'd1) begin
                    tail_d  = data_i;
                    count_d = 2'd2;
                end
            end
            2'b01: begin
                if (count_q != 2'd0) begin
                    head_d  = tail_q;
                    count_d = count_q - 2'd1;
                end
            end
            2'b11: begin
                // Occupancy is unchanged; the new word lands behind whatever
                // remains after the pop.
                if (count_q == 2'd2) begin
                    head_d = tail_q;
                    tail_d = data_i;
                end else if (count_q == 2'd1) begin
                    head_d = data_i;
                end else begin
                    head_d  = data_i;
                    count_d = 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);
    assign count_o = count_q;
    // Stale head contents are hidden so the stream data reads 0 when idle.
    assign data_o  = empty_o ? '0 : head_q;

endmodule

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: drains a registered-output FIFO into a valid/ready stream
// cut into bursts of BURST_LEN beats.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : drain enable
//   fifo_empty   : FIFO empty flag (updates on the edge that commits a read)
//   fifo_data    : FIFO read data, valid one cycle after a read strobe
//   fifo_rd_cs   : FIFO chip-select, mirrors fifo_rd_en
//   fifo_rd_en   : FIFO read strobe, one word per high cycle
//   busy         : state != IDLE, or a word is in flight or buffered
//   m_if         : output stream (m_valid, m_data, m_last, m_ready)
//   dbg_state_o  : current controller state
//   drained_cnt  : accepted-beat count, wraps at 16 bits; present only when
//                  FIFO_DRAIN_STATS_EN is defined
// Reads are issued only while the 2-entry skid buffer plus the word in flight
// cannot exceed two words, so the buffer never overflows.
module fifo_drain_ctrl
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd_cs,
    output logic                  fifo_rd_en,
    output logic                  busy,
    fifo_drain_ctrl_if.master     m_if,
    output drain_state_e          dbg_state_o
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [STATS_CNT_W-1:0] drained_cnt
`endif
);

    localparam int                BEAT_W   = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0] BEAT_MAX = BEAT_W'(BURST_LEN - 1);

    drain_state_e          state_q, state_d;
    logic                  in_flight_q;
    logic [BEAT_W-1:0]     beat_q, beat_d;

    logic [DATA_WIDTH-1:0] buf_data;
    logic [1:0]            buf_count;
    logic                  buf_full;
    logic                  buf_empty;
    logic                  pop;
    logic [2:0]            occupancy;
    logic                  credit_ok;
    logic                  rd_en;

    // A word strobed on one edge is presented on fifo_data after it and
    // captured on the next edge, so in_flight_q doubles as the push strobe.
    drain_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .push_i  (in_flight_q),
        .pop_i   (pop),
        .data_i  (fifo_data),
        .data_o  (buf_data),
        .count_o (buf_count),
        .full_o  (buf_full),
        .empty_o (buf_empty)
    );

    assign pop = !buf_empty && m_if.m_ready;

    // Words committed to the buffer after this edge, counting a beat leaving
    // now; a beat leaving this cycle frees a slot for a back-to-back read.
    assign occupancy = {1'b0, buf_count} + {2'b00, in_flight_q} - {2'b00, pop};
    assign credit_ok = !(buf_full && !pop) && (occupancy < 3'd2);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en) state_d = ST_RUN;
            ST_RUN:  if (!en) state_d = ST_STOP;
            ST_STOP: begin
                if (en) begin
                    state_d = ST_RUN;
                end else if (!in_flight_q && buf_empty) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        rd_en = en && !fifo_empty && (state_q == ST_RUN) && credit_ok;
        busy  = (state_q != ST_IDLE) || in_flight_q || !buf_empty;
    end

    // Beat counter: a burst abandoned through STOP restarts from beat 0.
    always_comb begin
        beat_d = beat_q;
        if ((state_q == ST_STOP) && (state_d == ST_IDLE)) begin
            beat_d = '0;
        end else if (pop) begin
            beat_d = (beat_q == BEAT_MAX) ? '0 : beat_q + BEAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight_q <= 1'b0;
            beat_q      <= '0;
        end else begin
            in_flight_q <= rd_en;
            beat_q      <= beat_d;
        end
    end

`ifdef FIFO_DRAIN_STATS_EN
    logic [STATS_CNT_W-1:0] drained_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drained_q <= '0;
        end else if (pop) begin
            drained_q <= drained_q + STATS_CNT_W'(1);
        end
    end

    assign drained_cnt = drained_q;
`endif

    assign fifo_rd_en   = rd_en;
    assign fifo_rd_cs   = rd_en;
    assign m_if.m_valid = !buf_empty;
    assign m_if.m_data  = buf_data;
    assign m_if.m_last  = !buf_empty && (beat_q == BEAT_MAX);
    assign dbg_state_o  = state_q;

endmodule
